// File: rtl/rv_types.sv
// rv_types: shared scalar types, UART register offsets and FSM state encodings.
package rv_types;
    typedef logic [7:0]  u8_t;
    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;
    localparam logic [2:0] SIO_DATA = 3'd0;
    localparam logic [2:0] SIO_STAT = 3'd1;
    localparam logic [2:0] SIO_CTRL = 3'd2;
    localparam logic [2:0] SIO_DIV  = 3'd3;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/rv_sio_rx.sv
// rv_sio_rx: 8N1 receiver with rxd synchronizer, holding register and error flags.
module rv_sio_rx import rv_types::*; #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             xreset,
    input  logic             rxd,
    input  logic             i_pop,
    input  logic             i_clr_err,
    input  logic [DIV_W-1:0] i_div,
    output u8_t              o_byte,
    output logic             o_full,
    output logic             o_overrun,
    output logic             o_frame_err
);
    localparam logic [DIV_W-1:0] ONE = 1;
    logic             r_s1, r_s2, r_prev;
    rx_state_t        r_st;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    u8_t              r_sh;
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_s1        <= 1'b1;
            r_s2        <= 1'b1;
            r_prev      <= 1'b1;
            r_st        <= RX_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_sh        <= '0;
            o_byte      <= '0;
            o_full      <= 1'b0;
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_s1   <= rxd;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_cnt  <= r_cnt - ONE;
            if (i_pop) o_full <= 1'b0;
            if (i_clr_err) begin
                o_overrun   <= 1'b0;
                o_frame_err <= 1'b0;
            end
            case (r_st)
                RX_IDLE: if (r_prev && !r_s2) begin
                    r_st  <= RX_START;
                    r_cnt <= (i_div >> 1) - ONE;
                end
                RX_START: if (r_cnt == '0) begin
                    r_st  <= r_s2 ? RX_IDLE : RX_DATA;
                    r_cnt <= i_div - ONE;
                    r_bit <= '0;
                end
                RX_DATA: if (r_cnt == '0) begin
                    r_sh  <= {r_s2, r_sh[7:1]};
                    r_bit <= r_bit + 3'd1;
                    r_cnt <= i_div - ONE;
                    if (r_bit == 3'd7) r_st <= RX_STOP;
                end
                RX_STOP: if (r_cnt == '0) begin
                    // a load on the same edge as a pop leaves the byte pending without overrun
                    o_byte <= r_sh;
                    o_full <= 1'b1;
                    if (o_full && !i_pop) o_overrun <= 1'b1;
                    if (!r_s2) o_frame_err <= 1'b1;
                    r_st <= RX_IDLE;
                end
                default: r_st <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/rv_sio_uart.sv
// rv_sio_uart: memory-mapped 8N1 UART with TX holding register, registered read data
// and level interrupt; receive path lives in rv_sio_rx.
module rv_sio_uart import rv_types::*; #(
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = 16'd868
) (
    input  logic       clk,
    input  logic       xreset,
    input  logic [4:0] adr,
    input  logic       cs,
    input  logic       rdy,
    input  u4_t        we,
    input  logic       re,
    output logic       irq,
    input  u32_t       dw,
    output u32_t       dr,
    output logic       txd,
    input  logic       rxd,
    input  logic       dsr,
    output logic       dtr,
    output logic       txen
);
    localparam logic [DIV_W-1:0] ONE = 1;
    localparam logic [DIV_W-1:0] TWO = 2;
    logic [2:0]       w_reg;
    logic             w_wr, w_rd, w_pop, w_clr, w_load, w_tx_idle, w_unused;
    logic [DIV_W-1:0] w_div;
    u32_t             w_rdata;
    u8_t              w_rx_byte;
    logic             w_rx_full, w_overrun, w_frame_err;
    logic [2:0]       r_ctrl;
    logic [DIV_W-1:0] r_div, r_tx_cnt;
    u8_t              r_thr, r_tx_sh;
    logic             r_tx_empty, r_txd, r_txen;
    logic [2:0]       r_tx_bit;
    tx_state_t        r_tx_st;
    u32_t             r_dr;
    assign w_reg     = adr[4:2];
    assign w_wr      = cs & rdy & we[0];
    assign w_rd      = cs & rdy & re;
    assign w_pop     = w_rd && w_reg == SIO_DATA;
    assign w_clr     = w_wr && w_reg == SIO_CTRL && dw[3];
    assign w_div     = (r_div < TWO) ? TWO : r_div;
    assign w_tx_idle = r_tx_st == TX_IDLE;
    // the shifter takes the holding register when idle or exactly at the end of a stop bit
    assign w_load    = !r_tx_empty && (w_tx_idle || (r_tx_st == TX_STOP && r_tx_cnt == '0));
    assign w_unused  = ^{adr[1:0], we[3:2], dw[31:DIV_W]};
    always_comb begin
        w_rdata = (w_reg == SIO_DATA) ? {24'b0, w_rx_byte} :
                  (w_reg == SIO_STAT) ? {26'b0, dsr, w_frame_err, w_overrun, w_tx_idle, r_tx_empty, w_rx_full} :
                  (w_reg == SIO_CTRL) ? {29'b0, r_ctrl} :
                  (w_reg == SIO_DIV)  ? u32_t'(r_div) : '0;
    end
    rv_sio_rx #(.DIV_W(DIV_W)) u_rx (
        .clk(clk), .xreset(xreset), .rxd(rxd), .i_pop(w_pop), .i_clr_err(w_clr), .i_div(w_div),
        .o_byte(w_rx_byte), .o_full(w_rx_full), .o_overrun(w_overrun), .o_frame_err(w_frame_err)
    );
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_ctrl     <= '0;
            r_div      <= DIV_DEFAULT;
            r_thr      <= '0;
            r_tx_empty <= 1'b1;
            r_dr       <= '0;
            r_tx_st    <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_txd      <= 1'b1;
            r_txen     <= 1'b0;
        end else begin
            if (w_wr && w_reg == SIO_CTRL) r_ctrl <= dw[2:0];
            if (w_wr && w_reg == SIO_DIV) r_div[7:0] <= dw[7:0];
            if (cs && rdy && we[1] && w_reg == SIO_DIV) r_div[DIV_W-1:8] <= dw[DIV_W-1:8];
            if (w_wr && w_reg == SIO_DATA && r_tx_empty) begin
                r_thr      <= dw[7:0];
                r_tx_empty <= 1'b0;
            end
            if (w_rd) r_dr <= w_rdata;
            r_tx_cnt <= r_tx_cnt - ONE;
            if (w_load) begin
                r_tx_st    <= TX_START;
                r_tx_sh    <= r_thr;
                r_tx_empty <= 1'b1;
                r_txd      <= 1'b0;
                r_txen     <= 1'b1;
                r_tx_cnt   <= w_div - ONE;
            end else if (r_tx_cnt == '0) begin
                case (r_tx_st)
                    TX_START: begin
                        r_tx_st  <= TX_DATA;
                        r_txd    <= r_tx_sh[0];
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= '0;
                        r_tx_cnt <= w_div - ONE;
                    end
                    TX_DATA: begin
                        r_tx_cnt <= w_div - ONE;
                        r_tx_st  <= (r_tx_bit == 3'd7) ? TX_STOP : TX_DATA;
                        r_txd    <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[0];
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 3'd1;
                    end
                    TX_STOP: begin
                        r_tx_st <= TX_IDLE;
                        r_txen  <= 1'b0;
                    end
                    default: r_tx_st <= TX_IDLE;
                endcase
            end
        end
    end
    assign irq  = (r_ctrl[0] & w_rx_full) | (r_ctrl[1] & r_tx_empty);
    assign dtr  = r_ctrl[2];
    assign txd  = r_txd;
    assign txen = r_txen;
    assign dr   = r_dr;
endmodule

// File: tb/tb_rv_sio_uart.sv
// tb_rv_sio_uart: directed stimulus with a read-data scoreboard and a serial TX frame monitor.
module tb_rv_sio_uart;
    localparam int D = 4;
    logic        clk = 1'b0, xreset = 1'b0, cs = 1'b0, rdy = 1'b1, re = 1'b0, rxd = 1'b1, dsr = 1'b0;
    logic [4:0]  adr = '0;
    logic [3:0]  we = '0;
    logic [31:0] dw = '0;
    logic        irq, txd, dtr, txen;
    logic [31:0] dr;
    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic [7:0]  tx_q[$];
    logic        rd_q = 1'b0;
    logic [9:0]  fr;
    int          bad;

    always #5 clk = ~clk;

    rv_sio_uart dut (
        .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy), .we(we), .re(re),
        .irq(irq), .dw(dw), .dr(dr), .txd(txd), .rxd(rxd), .dsr(dsr), .dtr(dtr), .txen(txen)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_q <= cs & rdy & re;

    // read data is valid the cycle after the access edge
    always @(negedge clk) begin
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read got %h expected none", dr);
            end else chk(nm_q.pop_front(), dr, exp_q.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (txen) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_frame got txen 1 expected 0");
                fr = 10'h3ff;
            end else fr = {1'b1, tx_q.pop_front(), 1'b0};
            bad = 0;
            for (int c = 0; c < 10 * D; c++) begin
                if (c > 0) @(negedge clk);
                if (txd !== fr[c / D] || txen !== 1'b1) bad++;
            end
            chk("tx_frame_bits", bad, 0);
            @(negedge clk);
            chk("txen_after_frame", {31'b0, txen}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] w);
        adr = {r, 2'b00};
        dw  = d;
        we  = w;
        cs  = 1'b1;
        @(negedge clk);
        cs  = 1'b0;
        we  = '0;
    endtask

    task automatic bus_read(input logic [2:0] r, input logic [31:0] e, input string n);
        adr = {r, 2'b00};
        re  = 1'b1;
        cs  = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(n);
        @(negedge clk);
        cs  = 1'b0;
        re  = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        idle(D);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(D);
        end
        rxd = stop;
        idle(D);
        rxd = 1'b1;
        idle(2 * D);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_txd", {31'b0, txd}, 1);
        chk("reset_txen", {31'b0, txen}, 0);
        chk("reset_irq", {31'b0, irq}, 0);
        chk("reset_dtr", {31'b0, dtr}, 0);
        chk("reset_dr", dr, 0);
        xreset = 1'b1;
        @(negedge clk);
        bus_read(3'd1, 32'h06, "stat_reset");
        bus_read(3'd3, 32'd868, "div_reset");
        bus_read(3'd2, 32'h0, "ctrl_reset");
        bus_read(3'd5, 32'h0, "reg5_reads_zero");
        bus_write(3'd3, 32'h4, 4'b0011);
        bus_read(3'd3, 32'h4, "div_write");
        bus_write(3'd2, 32'h6, 4'b0001);
        chk("dtr_set", {31'b0, dtr}, 1);
        chk("irq_txie_idle", {31'b0, irq}, 1);
        tx_q.push_back(8'h55);
        bus_write(3'd0, 32'h55, 4'b0001);
        chk("irq_tx_loaded", {31'b0, irq}, 0);
        bus_write(3'd0, 32'hAA, 4'b0001);
        chk("irq_after_transfer", {31'b0, irq}, 1);
        bus_read(3'd1, 32'h02, "stat_tx_busy");
        idle(50);
        bus_read(3'd1, 32'h06, "stat_tx_done");
        bus_write(3'd2, 32'h0, 4'b0001);
        send_rx(8'hA3, 1'b1);
        bus_read(3'd1, 32'h07, "stat_rx_full");
        bus_read(3'd0, 32'hA3, "rx_data");
        bus_read(3'd1, 32'h06, "stat_after_pop");
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(3'd1, 32'h0F, "stat_overrun");
        bus_read(3'd0, 32'h22, "rx_overwrite");
        bus_write(3'd2, 32'h8, 4'b0001);
        bus_read(3'd1, 32'h06, "stat_clr_overrun");
        send_rx(8'h5A, 1'b0);
        bus_read(3'd1, 32'h17, "stat_frame_err");
        bus_read(3'd0, 32'h5A, "rx_frame_byte");
        bus_write(3'd2, 32'h8, 4'b0001);
        bus_read(3'd1, 32'h06, "stat_clr_frame_err");
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        idle(50);
        bus_read(3'd1, 32'h06, "stat_after_glitch");
        bus_write(3'd2, 32'h1, 4'b0001);
        chk("irq_rxie_empty", {31'b0, irq}, 0);
        send_rx(8'h3C, 1'b1);
        chk("irq_rx_full", {31'b0, irq}, 1);
        bus_read(3'd0, 32'h3C, "rx_irq_data");
        chk("irq_after_pop", {31'b0, irq}, 0);
        bus_read(3'd2, 32'h1, "ctrl_read");
        dsr = 1'b1;
        bus_read(3'd1, 32'h26, "stat_dsr");
        dsr = 1'b0;
        bus_write(3'd3, 32'h1207, 4'b0001);
        bus_read(3'd3, 32'h7, "div_lane0_only");
        bus_write(3'd3, 32'h1207, 4'b0010);
        bus_read(3'd3, 32'h1207, "div_lane1");
        bus_write(3'd6, 32'hFF, 4'b0001);
        bus_read(3'd6, 32'h0, "reg6_write_ignored");
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("tx_queue_drained", tx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
